timer_driver: RTL and testbench
===============================

TIMER_DRIVER -- requirements
Module: timer_driver

Interface
REQ-001 The block SHALL have parameter TICK_W, default 16, setting the width of the timeout counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_start, input, 1, a one-cycle pulse that starts the timer with cmd_period and cmd_continuous.
REQ-005 The block SHALL have port cmd_period, input, 32, the timer period in clocks minus 1.
REQ-006 The block SHALL have port cmd_continuous, input, 1, selecting continuous mode (1) or one-shot mode (0).
REQ-007 The block SHALL have port cmd_stop, input, 1, a one-cycle pulse that stops the timer.
REQ-008 The block SHALL have port cmd_snap, input, 1, a one-cycle pulse that requests a counter snapshot.
REQ-009 The block SHALL have port irq, input, 1, the timer interrupt.
REQ-010 The block SHALL have Avalon-MM master ports: avm_address output 3, avm_chipselect output 1, avm_write_n output 1, avm_writedata output 16, avm_readdata input 16.
REQ-011 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE or RUN.
REQ-012 The block SHALL have port running, output, 1, high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port tick, output, 1, a one-cycle pulse for each serviced timeout.
REQ-014 The block SHALL have port tick_count, output, TICK_W, the count of serviced timeouts.
REQ-015 The block SHALL have ports snap_valid, output, 1, and snap_value, output, 32, giving the snapshot result.

Function
REQ-016 Target register map SHALL be: 0 = status (bit0 TO, bit1 RUN; any write clears TO); 1 = control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP); 2 = period_l; 3 = period_h; 4 = snap_l; 5 = snap_h (any write to 4 or 5 captures the counter).
REQ-017 Bus idle SHALL be: chipselect=0, write_n=1, address=0, writedata=0.
REQ-018 Every write SHALL take exactly one cycle, with chipselect=1 and write_n=0; the interface has no waitrequest.
REQ-019 A read SHALL drive chipselect=1, write_n=1 and the address for one cycle; avm_readdata SHALL be sampled in the following cycle.
REQ-020 FSM states SHALL be IDLE, WR_PL, WR_PH, WR_CTRL, RUN, RD_STAT, CHK_STAT, CLR_STAT, WR_STOP, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE.
REQ-021 In IDLE, cmd_start SHALL move to WR_PL, latch period and mode, and clear tick_count; cmd_start SHALL be ignored in all other states.
REQ-022 The start sequence SHALL be: WR_PL writes addr2 = period[15:0]; WR_PH writes addr3 = period[31:16]; WR_CTRL writes addr1 = 0x7 (continuous) or 0x5 (one-shot); then the FSM enters RUN.
REQ-023 Period SHALL be written before control, because a period write stops the target counter.
REQ-024 RUN priority SHALL be, highest first: irq, then stop_pend, then snap_pend.
REQ-025 On irq, the FSM SHALL go RD_STAT (read addr0), then CHK_STAT (sample avm_readdata).
REQ-026 In CHK_STAT, if bit0=1 the FSM SHALL go to CLR_STAT; otherwise it SHALL return to RUN with no count.
REQ-027 CLR_STAT SHALL write addr0 = 0, pulse tick, increment tick_count (wrapping from all-ones to 0), then go to RUN if the sampled RUN bit was 1, else IDLE.
REQ-028 cmd_stop SHALL set stop_pend in any state except IDLE; in IDLE it SHALL be ignored with no bus cycle.
REQ-029 A stop SHALL be serviced as WR_STOP, writing addr1 = 0x8, then IDLE, clearing both pending flags.
REQ-030 cmd_snap SHALL set snap_pend only in RUN or the irq-service states.
REQ-031 A snapshot SHALL be serviced as: SNAP_WR writes addr4 = 0; SNAP_RL reads addr4; SNAP_RH reads addr5 and samples the low half; SNAP_DONE samples the high half, updates snap_value, pulses snap_valid for 1 cycle, and returns to RUN.
REQ-032 A pulse arriving while the same flag is already pending SHALL be merged into the existing pending request.

Reset
REQ-033 On reset_n=0 the block SHALL, asynchronously: enter IDLE, drive the bus to idle values, and clear busy, running, tick, tick_count, snap_valid, snap_value, stop_pend and snap_pend.
REQ-034 Reset asserted mid-sequence SHALL abort the current bus cycle immediately, with no completion.

Verification
REQ-035 Start: cmd_start with period=0x0098967F, cont=1 -> writes addr2=0x967F, addr3=0x0098, addr1=0x0007 on 3 consecutive cycles; running=1 and busy=0 on the 4th cycle.
REQ-036 Continuous timeout: irq=1 with status readdata=0x0003 -> read addr0, then write addr0=0x0000 two cycles later; tick pulses; tick_count 0->1; FSM returns to RUN.
REQ-037 One-shot: cont=0 -> ctrl write 0x0005; irq with status=0x0001 -> clear write, then IDLE, running=0.
REQ-038 Simultaneous irq and cmd_stop in RUN -> full irq service first, then addr1=0x0008, then IDLE.
REQ-039 Snapshot: cmd_snap in RUN, slave returns 0x1234 then 0x0056 -> snap_value=0x00561234 and snap_valid pulses 5 cycles after cmd_snap.
REQ-040 Wrap and reset: tick_count=0xFFFF plus one timeout -> 0x0000; reset_n low during WR_PH -> bus idle and FSM in IDLE in the same cycle.

Source files
------------

// File: rtl/timer_driver_if.sv
// Avalon-MM bus between the timer driver (master) and the timer peripheral (slave).
interface timer_driver_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/timer_driver.sv
// Command-driven sequencer for an Avalon-MM interval timer: programs period/mode,
// services timeout interrupts, handles stop requests and counter snapshots.
module timer_driver #(
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    input  logic              irq,
    timer_driver_if.master    avm,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              snap_valid,
    output logic [31:0]       snap_value
);

    typedef enum logic [3:0] {
        StIdle, StWrPl, StWrPh, StWrCtrl, StRun, StRdStat, StChkStat, StClrStat,
        StWrStop, StSnapWr, StSnapRl, StSnapRh, StSnapDone
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic              cont_q, cont_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic              run_bit_q, run_bit_d;
    logic              stop_pend_q, stop_pend_d;
    logic              snap_pend_q, snap_pend_d;
    logic [15:0]       snap_lo_q, snap_lo_d;
    logic [31:0]       snap_value_q, snap_value_d;

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            period_q     <= '0;
            cont_q       <= 1'b0;
            tick_count_q <= '0;
            run_bit_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            snap_lo_q    <= '0;
            snap_value_q <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            tick_count_q <= tick_count_d;
            run_bit_q    <= run_bit_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
        end
    end

    // Next-state logic and pending-request bookkeeping.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cont_d       = cont_q;
        tick_count_d = tick_count_q;
        run_bit_d    = run_bit_q;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        // Repeated pulses simply re-set an already pending flag.
        stop_pend_d  = stop_pend_q | (cmd_stop && state_q != StIdle);
        snap_pend_d  = snap_pend_q |
                       (cmd_snap && (state_q inside {StRun, StRdStat, StChkStat, StClrStat}));

        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    state_d      = StWrPl;
                    period_d     = cmd_period;
                    cont_d       = cmd_continuous;
                    tick_count_d = '0;
                end
            end
            // Period goes first: writing it halts the target counter.
            StWrPl:   state_d = StWrPh;
            StWrPh:   state_d = StWrCtrl;
            StWrCtrl: state_d = StRun;
            StRun: begin
                if (irq) begin
                    state_d = StRdStat;
                end else if (stop_pend_q) begin
                    state_d = StWrStop;
                end else if (snap_pend_q) begin
                    state_d     = StSnapWr;
                    snap_pend_d = 1'b0;
                end
            end
            StRdStat: state_d = StChkStat;
            StChkStat: begin
                run_bit_d = avm.avm_readdata[1];
                state_d   = avm.avm_readdata[0] ? StClrStat : StRun;
            end
            StClrStat: begin
                tick_count_d = tick_count_q + TICK_W'(1);
                state_d      = run_bit_q ? StRun : StIdle;
            end
            StWrStop: state_d = StIdle;
            StSnapWr: state_d = StSnapRl;
            StSnapRl: state_d = StSnapRh;
            StSnapRh: begin
                snap_lo_d = avm.avm_readdata;
                state_d   = StSnapDone;
            end
            StSnapDone: begin
                snap_value_d = {avm.avm_readdata, snap_lo_q};
                state_d      = StRun;
            end
            default: state_d = StIdle;
        endcase

        // Nothing stays pending once the timer is no longer running.
        if (state_d == StIdle) begin
            stop_pend_d = 1'b0;
            snap_pend_d = 1'b0;
        end
    end

    // Bus cycle driven in each state; idle values everywhere else.
    always_comb begin
        avm.avm_chipselect = 1'b0;
        avm.avm_write_n    = 1'b1;
        avm.avm_address    = 3'd0;
        avm.avm_writedata  = 16'h0000;
        unique case (state_q)
            StWrPl: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd2;
                avm.avm_writedata  = period_q[15:0];
            end
            StWrPh: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd3;
                avm.avm_writedata  = period_q[31:16];
            end
            StWrCtrl: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd1;
                avm.avm_writedata  = cont_q ? 16'h0007 : 16'h0005;
            end
            StRdStat: begin
                avm.avm_chipselect = 1'b1;
            end
            StClrStat: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
            end
            StWrStop: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd1;
                avm.avm_writedata  = 16'h0008;
            end
            StSnapWr: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = 3'd4;
            end
            StSnapRl: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_address    = 3'd4;
            end
            StSnapRh: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_address    = 3'd5;
            end
            default: ;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        running    = (state_q != StIdle);
        busy       = running && (state_q != StRun);
        tick       = (state_q == StClrStat);
        snap_valid = (state_q == StSnapDone);
        // Present the fresh snapshot in the same cycle as its valid pulse.
        snap_value = snap_valid ? {avm.avm_readdata, snap_lo_q} : snap_value_q;
        tick_count = tick_count_q;
    end

endmodule

// File: tb/tb_timer_driver.sv
// Randomized bench for timer_driver: a transaction-order model of the expected bus
// traffic plus timeout and snapshot counters, with directed timing checks.
module tb_timer_driver;
    localparam int unsigned TW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_start = 1'b0, cmd_continuous = 1'b0, cmd_stop = 1'b0;
    logic          cmd_snap = 1'b0, irq = 1'b0;
    logic [31:0]   cmd_period = '0;
    logic          busy, running, tick, snap_valid;
    logic [TW-1:0] tick_count;
    logic [31:0]   snap_value;

    timer_driver_if bus ();

    timer_driver #(.TICK_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_period(cmd_period),
        .cmd_continuous(cmd_continuous), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
        .irq(irq), .avm(bus), .busy(busy), .running(running), .tick(tick),
        .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Expected bus transactions in order: {is_write, address, write data (0 for reads)}.
    logic [19:0]   exp_q[$];
    bit            run_m = 0;
    logic [TW-1:0] tick_m = '0;
    int            tick_seen = 0, tick_exp = 0, snap_seen = 0, snap_exp_n = 0;
    logic [31:0]   snap_exp = '0;
    logic [15:0]   status_m = '0, snap_lo_m = '0, snap_hi_m = '0;
    bit            rd_pend = 0;
    logic [2:0]    rd_addr = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [19:0] rd(input logic [2:0] a);
        return {1'b0, a, 16'h0000};
    endfunction

    function automatic logic [15:0] slave_rd(input logic [2:0] a);
        case (a)
            3'd0:    return status_m;
            3'd4:    return snap_lo_m;
            3'd5:    return snap_hi_m;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [20:0] bus_word();
        return {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata};
    endfunction

    // One clock: slave answers the previous read after the edge, then bus monitor at negedge.
    task automatic step();
        logic [19:0] seen;
        logic [19:0] e;
        @(posedge clk);
        #1;
        if (rd_pend) begin
            bus.avm_readdata = slave_rd(rd_addr);
            rd_pend = 0;
        end
        @(negedge clk);
        if (bus.avm_chipselect) begin
            seen = {~bus.avm_write_n, bus.avm_address,
                    bus.avm_write_n ? 16'h0000 : bus.avm_writedata};
            if (exp_q.size() == 0) begin
                check_val("unexpected_bus_cycle", {1'b1, seen}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check_val("bus_cycle", seen, e);
            end
            if (bus.avm_write_n) begin
                rd_pend = 1;
                rd_addr = bus.avm_address;
            end
        end else begin
            check_val("bus_idle", {bus.avm_write_n, bus.avm_address, bus.avm_writedata},
                      {1'b1, 3'd0, 16'h0000});
        end
        if (tick) tick_seen++;
        if (snap_valid) begin
            snap_seen++;
            check_val("snap_value", snap_value, snap_exp);
        end
        cmd_start = 0;
        cmd_stop  = 0;
        cmd_snap  = 0;
        irq       = 0;
    endtask

    task automatic m_start(input logic [31:0] p, input bit c);
        if (!run_m) begin
            exp_q.push_back(wr(3'd2, p[15:0]));
            exp_q.push_back(wr(3'd3, p[31:16]));
            exp_q.push_back(wr(3'd1, c ? 16'h0007 : 16'h0005));
            run_m  = 1;
            tick_m = '0;
        end
    endtask

    task automatic m_irq(input logic [15:0] s);
        if (run_m) begin
            exp_q.push_back(rd(3'd0));
            if (s[0]) begin
                exp_q.push_back(wr(3'd0, 16'h0000));
                tick_m = tick_m + 1'b1;
                tick_exp++;
                if (!s[1]) run_m = 0;
            end
        end
    endtask

    task automatic m_stop();
        if (run_m) begin
            exp_q.push_back(wr(3'd1, 16'h0008));
            run_m = 0;
        end
    endtask

    task automatic m_snap();
        if (run_m) begin
            exp_q.push_back(wr(3'd4, 16'h0000));
            exp_q.push_back(rd(3'd4));
            exp_q.push_back(rd(3'd5));
            snap_exp = {snap_hi_m, snap_lo_m};
            snap_exp_n++;
        end
    endtask

    // Run until traffic has drained and the DUT is quiet, then compare the model.
    task automatic settle();
        int quiet = 0;
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (!busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 2) done = 1;
        end
        check_val("settle", done, 1);
        if (!done) exp_q.delete();
        check_val("running", running, run_m);
        check_val("tick_count", tick_count, tick_m);
        check_val("tick_pulses", tick_seen, tick_exp);
        check_val("snap_pulses", snap_seen, snap_exp_n);
    endtask

    task automatic do_start(input logic [31:0] p, input bit c);
        m_start(p, c);
        cmd_start = 1; cmd_period = p; cmd_continuous = c;
        settle();
    endtask

    task automatic do_irq(input logic [15:0] s);
        status_m = s;
        m_irq(s);
        irq = 1;
        settle();
    endtask

    task automatic do_stop();
        m_stop();
        cmd_stop = 1;
        settle();
    endtask

    task automatic do_snap();
        snap_lo_m = 16'($urandom);
        snap_hi_m = 16'($urandom);
        m_snap();
        cmd_snap = 1;
        settle();
    endtask

    task automatic do_irq_stop(input logic [15:0] s);
        status_m = s;
        m_irq(s);
        m_stop();
        irq = 1; cmd_stop = 1;
        settle();
    endtask

    task automatic do_irq_snap(input logic [15:0] s);
        status_m  = s;
        snap_lo_m = 16'($urandom);
        snap_hi_m = 16'($urandom);
        m_irq(s);
        m_snap();
        irq = 1;
        step();
        cmd_snap = 1;
        settle();
    endtask

    initial begin
        bus.avm_readdata = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_bus", bus_word(), {1'b0, 1'b1, 3'd0, 16'h0000});
        check_val("rst_running", running, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_tick", tick, 0);
        check_val("rst_tick_count", tick_count, 0);
        check_val("rst_snap_valid", snap_valid, 0);
        check_val("rst_snap_value", snap_value, 0);
        reset_n = 1;
        step();

        // Start sequence: three back-to-back writes, then RUN.
        m_start(32'h0098967F, 1);
        cmd_start = 1; cmd_period = 32'h0098967F; cmd_continuous = 1;
        step(); check_val("start_wr_pl", bus_word(), {1'b1, 1'b0, 3'd2, 16'h967F});
        step(); check_val("start_wr_ph", bus_word(), {1'b1, 1'b0, 3'd3, 16'h0098});
        step(); check_val("start_wr_ctrl", bus_word(), {1'b1, 1'b0, 3'd1, 16'h0007});
        step(); check_val("start_run", {running, busy}, 2'b10);
        settle();

        // Continuous timeout with status TO|RUN.
        status_m = 16'h0003;
        m_irq(16'h0003);
        irq = 1;
        step(); check_val("irq_rd", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, 5'b11000);
        step(); check_val("irq_chk_idle", bus.avm_chipselect, 0);
        step(); check_val("irq_clr", {bus_word(), tick}, {1'b1, 1'b0, 3'd0, 16'h0000, 1'b1});
        step(); check_val("irq_after", {tick, tick_count, running, busy}, {1'b0, 8'd1, 1'b1, 1'b0});
        settle();

        // Snapshot: valid on the fifth cycle after the request.
        snap_lo_m = 16'h1234; snap_hi_m = 16'h0056;
        m_snap();
        cmd_snap = 1;
        repeat (4) step();
        check_val("snap_not_yet", snap_valid, 0);
        step();
        check_val("snap_valid_pulse", snap_valid, 1);
        check_val("snap_value_fixed", snap_value, 32'h00561234);
        settle();

        // irq and stop together: irq service first, then stop.
        do_irq_stop(16'h0003);

        // One-shot: control 0x5, timeout with RUN=0 ends in IDLE.
        do_start($urandom, 0);
        do_irq(16'h0001);
        check_val("oneshot_idle", running, 0);

        // Counter wrap.
        do_start($urandom, 1);
        for (int k = 0; k < (1 << TW) - 1; k++) do_irq(16'h0003);
        check_val("wrap_pre", tick_count, {TW{1'b1}});
        do_irq(16'h0003);
        check_val("wrap_zero", tick_count, 0);

        // Random command mix.
        for (int n = 0; n < 150; n++) begin
            int op;
            logic [15:0] s;
            op = $urandom_range(0, 5);
            s  = 16'($urandom_range(0, 3));
            case (op)
                0: do_start($urandom, 1'($urandom_range(0, 1)));
                1: do_irq(s);
                2: do_stop();
                3: do_snap();
                4: do_irq_stop(s);
                default: do_irq_snap(s);
            endcase
        end

        // Reset in the middle of the start sequence.
        do_stop();
        m_start(32'hCAFE_BEEF, 1);
        cmd_start = 1; cmd_period = 32'hCAFE_BEEF; cmd_continuous = 1;
        step();
        step();
        check_val("pre_rst_wr_ph", bus_word(), {1'b1, 1'b0, 3'd3, 16'hCAFE});
        #2 reset_n = 0;
        #1;
        check_val("midrst_bus", bus_word(), {1'b0, 1'b1, 3'd0, 16'h0000});
        check_val("midrst_running", {running, busy}, 2'b00);
        exp_q.delete();
        run_m = 0; tick_m = '0; rd_pend = 0;
        @(negedge clk);
        reset_n = 1;
        settle();
        check_val("midrst_snap_value", snap_value, 0);

        do_start($urandom, 1);
        do_irq(16'h0003);
        do_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
